// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - WIDTH-bit LED pattern sequencer: rotate-left/right, bounce, bar-fill
// Define LED_PATTERN_BOUNCE_EN for the bounce mode; without it mode 10 is a rotate-left.
module led_pattern_engine #(
  parameter int WIDTH    = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_pattern,
  output logic [WIDTH-1:0]    led_out,
  output logic                step_pulse,
  output logic                wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [PERIOD_W-1:0] tick_cnt;
  logic [PERIOD_W-1:0] peff_m1;
  logic                step;
  logic [WIDTH-1:0]    nxt_pat;
  logic                nxt_wrap;

  // Period 0 behaves as 1; >= lets a shrunken period step immediately instead of wrapping.
  assign peff_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign step    = enable && (tick_cnt >= peff_m1);

`ifdef LED_PATTERN_BOUNCE_EN
  logic dir;
  logic nxt_dir;
`endif

  always_comb begin
    nxt_pat  = led_out;
    nxt_wrap = 1'b0;
`ifdef LED_PATTERN_BOUNCE_EN
    nxt_dir  = dir;
`endif
    case (mode)
      2'b01: begin
        if (led_out == '0) begin
          nxt_pat = ONE;
        end else begin
          nxt_pat  = {led_out[0], led_out[WIDTH-1:1]};
          nxt_wrap = led_out[0];
        end
      end
`ifdef LED_PATTERN_BOUNCE_EN
      2'b10: begin
        if (led_out == '0) begin
          nxt_pat = ONE;
          nxt_dir = 1'b0;
        end else if (!dir) begin
          if (led_out[WIDTH-1]) begin
            nxt_pat = led_out >> 1;
            nxt_dir = 1'b1;
          end else begin
            nxt_pat = led_out << 1;
          end
        end else begin
          if (led_out[0]) begin
            nxt_pat  = led_out << 1;
            nxt_dir  = 1'b0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_pat = led_out >> 1;
          end
        end
      end
`endif
      2'b11: begin
        if (&led_out) begin
          nxt_pat  = '0;
          nxt_wrap = 1'b1;
        end else begin
          nxt_pat = (led_out << 1) | ONE;
        end
      end
      default: begin
        if (led_out == '0) begin
          nxt_pat = ONE;
        end else begin
          nxt_pat  = {led_out[WIDTH-2:0], led_out[WIDTH-1]};
          nxt_wrap = led_out[WIDTH-1];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out    <= ONE;
      tick_cnt   <= '0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else if (load) begin
      led_out    <= load_pattern;
      tick_cnt   <= '0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else if (step) begin
      led_out    <= nxt_pat;
      tick_cnt   <= '0;
      step_pulse <= 1'b1;
      wrap       <= nxt_wrap;
    end else begin
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
      if (enable) begin
        tick_cnt <= tick_cnt + PERIOD_W'(1);
      end
    end
  end

`ifdef LED_PATTERN_BOUNCE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir <= 1'b0;
    end else if (load) begin
      dir <= 1'b0;
    end else if (step) begin
      dir <= nxt_dir;
    end
  end
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed bench for led_pattern_engine (WIDTH=8, PERIOD_W=16)
module tb_led_pattern_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] period = 16'd4;
  logic        load = 1'b0;
  logic [7:0]  load_pattern = 8'h00;
  logic [7:0]  led_out;
  logic        step_pulse;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  led_pattern_engine #(.WIDTH(8), .PERIOD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .period(period),
    .load(load), .load_pattern(load_pattern), .led_out(led_out),
    .step_pulse(step_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] RL_SEQ [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  localparam logic [7:0] BF_SEQ [9] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};
`ifdef LED_PATTERN_BOUNCE_EN
  localparam logic [7:0] BN_SEQ [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                         8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  localparam int BN_WRAP = 14;
`else
  localparam logic [7:0] BN_SEQ [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                         8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  localparam int BN_WRAP = 7;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] pat);
    load = 1'b1;
    load_pattern = pat;
    tick();
    load = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    check("rst_led", led_out, 8'h01);
    check("rst_step", step_pulse, 1'b0);
    check("rst_wrap", wrap, 1'b0);

    // rotate-left, period 4, from reset
    enable = 1'b1;
    mode = 2'b00;
    period = 16'd4;
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (c == 3) check("rl_nostep", step_pulse, 1'b0);
      end
      check("rl_led", led_out, RL_SEQ[s]);
      check("rl_step", step_pulse, 1'b1);
      check("rl_wrap", wrap, (s == 7) ? 1'b1 : 1'b0);
    end

    // rotate-right, period 0 steps every clock
    do_load(8'h01);
    check("ld_led", led_out, 8'h01);
    check("ld_step", step_pulse, 1'b0);
    mode = 2'b01;
    period = 16'd0;
    tick();
    check("rr_led0", led_out, 8'h80);
    check("rr_wrap0", wrap, 1'b1);
    check("rr_step0", step_pulse, 1'b1);
    tick();
    check("rr_led1", led_out, 8'h40);
    check("rr_wrap1", wrap, 1'b0);
    check("rr_step1", step_pulse, 1'b1);
    tick();
    check("rr_led2", led_out, 8'h20);
    check("rr_step2", step_pulse, 1'b1);

    // mode 10, period 1
    do_load(8'h01);
    mode = 2'b10;
    period = 16'd1;
    for (int s = 0; s < 15; s++) begin
      tick();
      check("bn_led", led_out, BN_SEQ[s]);
      check("bn_wrap", wrap, (s == BN_WRAP) ? 1'b1 : 1'b0);
    end

    // bar-fill, period 2
    do_load(8'h01);
    mode = 2'b11;
    period = 16'd2;
    for (int s = 0; s < 9; s++) begin
      tick();
      check("bf_nostep", step_pulse, 1'b0);
      tick();
      check("bf_led", led_out, BF_SEQ[s]);
      check("bf_wrap", wrap, (s == 7) ? 1'b1 : 1'b0);
    end

    // load while disabled, then hold
    enable = 1'b0;
    do_load(8'h00);
    check("hold_ld", led_out, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    check("hold_led", led_out, 8'h00);
    check("hold_step", step_pulse, 1'b0);
    enable = 1'b1;
    mode = 2'b00;
    period = 16'd3;
    tick();
    tick();
    check("zero_nostep", step_pulse, 1'b0);
    tick();
    check("zero_led", led_out, 8'h01);
    check("zero_step", step_pulse, 1'b1);
    check("zero_wrap", wrap, 1'b0);

    // load on a step cycle wins
    period = 16'd1;
    do_load(8'hA5);
    check("ldstep_led", led_out, 8'hA5);
    check("ldstep_step", step_pulse, 1'b0);
    check("ldstep_wrap", wrap, 1'b0);
    tick();
    check("after_ld_led", led_out, 8'h4B);
    check("after_ld_wrap", wrap, 1'b1);

    // period decrease mid-count
    do_load(8'h01);
    period = 16'd10;
    for (int i = 0; i < 7; i++) tick();
    check("pd_led_hold", led_out, 8'h01);
    check("pd_nostep", step_pulse, 1'b0);
    period = 16'd3;
    tick();
    check("pd_led", led_out, 8'h02);
    check("pd_step", step_pulse, 1'b1);
    tick();
    tick();
    check("pd_gap", step_pulse, 1'b0);
    tick();
    check("pd_led2", led_out, 8'h04);

    // asynchronous reset while pulses are high
    period = 16'd1;
    tick();
    check("ar_pre_step", step_pulse, 1'b1);
    rst_n = 1'b0;
    #1;
    check("ar_led", led_out, 8'h01);
    check("ar_step", step_pulse, 1'b0);
    check("ar_wrap", wrap, 1'b0);
    period = 16'd4;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("ar_nostep", step_pulse, 1'b0);
    tick();
    check("ar_first_led", led_out, 8'h02);
    check("ar_first_step", step_pulse, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
